div_unit: RTL and testbench

Iterative 32-bit integer divider for the LoongArch execute stage. It sits beside the ALU and takes the same rj/rk operand pair from operand select. Its result is muxed after the ALU result toward writeback. It implements div.w, mod.w, div.wu and mod.wu with a restoring algorithm at one quotient bit per cycle. A valid/ready handshake on each side lets the core stall while a division is in flight.

---
 rtl/div_unit_pkg.sv | 28 ++
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 162 ++++++++++++++++
 tb/tb_div_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: width, FSM states, div_op bit
// positions and sign helpers used by the decoder and result fixup.
package div_unit_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_OP_DIVW  = 0;
  localparam int unsigned DIV_OP_MODW  = 1;
  localparam int unsigned DIV_OP_DIVWU = 2;
  localparam int unsigned DIV_OP_MODWU = 3;

  function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] v,
                                               input logic              is_signed);
    return (is_signed && v[DIV_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DIV_W-1:0] div_fixup(input logic [DIV_W-1:0] v,
                                                 input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_W-1:0] rem_i,
  input  logic [DIV_W-1:0] quo_i,
  input  logic [DIV_W-1:0] dvsr_i,
  output logic [DIV_W-1:0] rem_o,
  output logic [DIV_W-1:0] quo_o
);

  logic [DIV_W:0]   shifted;
  logic [DIV_W-1:0] diff;
  logic             fits;

  // The shifted value keeps rem's top bit so large unsigned divisors still
  // compare correctly; when it fits the difference is below 2^32.
  always_comb begin
    shifted = {rem_i, quo_i[DIV_W-1]};
    fits    = (shifted >= {1'b0, dvsr_i});
    diff    = shifted[DIV_W-1:0] - dvsr_i;
    if (fits) begin
      rem_o = diff;
      quo_o = {quo_i[DIV_W-2:0], 1'b1};
    end else begin
      rem_o = shifted[DIV_W-1:0];
      quo_o = {quo_i[DIV_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (div.w/mod.w/div.wu/mod.wu) with valid/ready
// handshakes. Define DIV_EARLY_OUT_EN to finish immediately when |src1| < |src2|.
module div_unit
  import div_unit_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [3:0]       div_op,
  input  logic [DIV_W-1:0] div_src1,
  input  logic [DIV_W-1:0] div_src2,
  input  logic             div_flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DIV_W-1:0] div_result
);

  div_state_e       state_q, state_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] dvsr_q, dvsr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             want_rem_q, want_rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div_ready_q, div_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [DIV_W-1:0] result_q, result_d;

  logic             signed_op;
  logic             want_rem_in;
  logic             r_neg_in;
  logic [DIV_W-1:0] a_mag;
  logic [DIV_W-1:0] b_mag;
  logic [DIV_W-1:0] step_rem;
  logic [DIV_W-1:0] step_quo;

  div_step u_div_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    signed_op   = div_op[DIV_OP_DIVW] | div_op[DIV_OP_MODW];
    want_rem_in = div_op[DIV_OP_MODW] | div_op[DIV_OP_MODWU];
    r_neg_in    = signed_op & div_src1[DIV_W-1];
    a_mag       = div_abs(div_src1, signed_op);
    b_mag       = div_abs(div_src2, signed_op);

    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    want_rem_d  = want_rem_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    div_ready_d = div_ready_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (div_valid && div_ready_q) begin
          want_rem_d  = want_rem_in;
          q_neg_d     = signed_op & (div_src1[DIV_W-1] ^ div_src2[DIV_W-1]);
          r_neg_d     = r_neg_in;
          dvsr_d      = b_mag;
          rem_d       = '0;
          quo_d       = a_mag;
          cnt_d       = 5'd31;
          div_ready_d = 1'b0;
          if (div_src2 == '0) begin
            state_d     = DIV_DONE;
            res_valid_d = 1'b1;
            result_d    = want_rem_in ? div_src1 : '1;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            state_d     = DIV_DONE;
            res_valid_d = 1'b1;
            rem_d       = a_mag;
            quo_d       = '0;
            result_d    = want_rem_in ? div_fixup(a_mag, r_neg_in) : '0;
          end
`endif
          else begin
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 5'd1;
        // Result is fixed up from the final step's outputs so it is
        // registered the same edge res_valid rises.
        if (cnt_q == 5'd0) begin
          state_d     = DIV_DONE;
          res_valid_d = 1'b1;
          result_d    = want_rem_q ? div_fixup(step_rem, r_neg_q)
                                   : div_fixup(step_quo, q_neg_q);
        end
      end
      DIV_DONE: begin
        if (res_ready) begin
          state_d     = DIV_IDLE;
          res_valid_d = 1'b0;
          div_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = DIV_IDLE;
        res_valid_d = 1'b0;
        div_ready_d = 1'b1;
      end
    endcase

    if (div_flush) begin
      state_d     = DIV_IDLE;
      res_valid_d = 1'b0;
      div_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= DIV_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      want_rem_q  <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      want_rem_q  <= want_rem_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      div_ready_q <= div_ready_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
    end
  end

  assign div_ready  = div_ready_q;
  assign res_valid  = res_valid_q;
  assign div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic        div_ready;
  logic [3:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] div_result;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_op     (div_op),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .div_flush  (div_flush),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero like LoongArch.
  function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    bit     sgn;
    bit     rem;
    longint sa, sb, q, r;
    sgn = op[0] | op[1];
    rem = op[1] | op[3];
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return rem ? r[31:0] : q[31:0];
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    bit     sgn;
    longint ma, mb;
    sgn = op[0] | op[1];
    if (b == 32'd0) return 0;
    ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (EARLY && (ma < mb)) return 0;
    return 32;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int hold);
    int          edges;
    bit          ready_hi;
    bit          unstable;
    logic [31:0] exp;
    exp = model_res(op, a, b);
    @(negedge clk);
    check({tag, " ready_before"}, 32'(div_ready), 32'd1);
    div_valid = 1'b1;
    div_op    = op;
    div_src1  = a;
    div_src2  = b;
    @(negedge clk);
    div_valid = 1'b0;
    div_op    = 4'($urandom);
    div_src1  = $urandom;
    div_src2  = $urandom;
    edges     = 0;
    ready_hi  = 1'b0;
    while (!res_valid && edges < 40) begin
      if (div_ready) ready_hi = 1'b1;
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'(model_lat(op, a, b)));
    check({tag, " ready_low_busy"}, 32'(ready_hi), 32'd0);
    check({tag, " result"}, div_result, exp);
    if (hold > 0) begin
      unstable = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (!res_valid || div_result !== exp) unstable = 1'b1;
      end
      check({tag, " hold_stable"}, 32'(unstable), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " valid_after_hs"}, 32'(res_valid), 32'd0);
    check({tag, " ready_after_hs"}, 32'(div_ready), 32'd1);
  endtask

  initial begin
    bit          seen;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int unsigned sel;

    resetn    = 1'b0;
    div_valid = 1'b0;
    div_op    = 4'd0;
    div_src1  = 32'd0;
    div_src2  = 32'd0;
    div_flush = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset div_ready", 32'(div_ready), 32'd1);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset div_result", div_result, 32'd0);
    resetn = 1'b1;

    run_op(4'b0001, 32'd100, 32'd7, "divw_100_7", 10);
    run_op(4'b0010, 32'd100, 32'd7, "modw_100_7", 0);
    run_op(4'b0001, 32'hFFFF_FFF9, 32'd2, "divw_m7_2", 0);
    run_op(4'b0010, 32'hFFFF_FFF9, 32'd2, "modw_m7_2", 0);
    run_op(4'b0100, 32'hFFFF_FFF9, 32'd2, "divwu_fff9_2", 0);
    run_op(4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, "divw_ovf", 0);
    run_op(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, "modw_ovf", 0);
    run_op(4'b0100, 32'd5, 32'd0, "divwu_5_0", 0);
    run_op(4'b1000, 32'd5, 32'd0, "modwu_5_0", 0);
    run_op(4'b0010, 32'hFFFF_FFF0, 32'd0, "modw_neg_0", 0);
    run_op(4'b0100, 32'd3, 32'd10, "divwu_3_10", 0);
    run_op(4'b1000, 32'd3, 32'd10, "modwu_3_10", 0);
    run_op(4'b0010, 32'hFFFF_FFFD, 32'd10, "modw_m3_10", 0);
    run_op(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divwu_big", 0);
    run_op(4'b1000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "modwu_big", 0);

    // Flush in the middle of a calculation.
    @(negedge clk);
    div_valid = 1'b1; div_op = 4'b0001; div_src1 = 32'd1000; div_src2 = 32'd3;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (16) @(negedge clk);
    div_flush = 1'b1;
    @(negedge clk);
    div_flush = 1'b0;
    check("flush_calc ready", 32'(div_ready), 32'd1);
    check("flush_calc valid", 32'(res_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("flush_calc no_result", 32'(seen), 32'd0);
    run_op(4'b0001, 32'd1000, 32'd3, "after_flush", 0);

    // Flush wins over a simultaneous accept.
    @(negedge clk);
    div_valid = 1'b1; div_flush = 1'b1; div_op = 4'b0100; div_src1 = 32'd9; div_src2 = 32'd0;
    @(negedge clk);
    div_valid = 1'b0; div_flush = 1'b0;
    check("flush_accept ready", 32'(div_ready), 32'd1);
    check("flush_accept valid", 32'(res_valid), 32'd0);

    // Flush wins over a simultaneous res_ready in DONE.
    div_valid = 1'b1; div_op = 4'b0100; div_src1 = 32'd9; div_src2 = 32'd0;
    @(negedge clk);
    div_valid = 1'b0;
    check("flush_done pre_valid", 32'(res_valid), 32'd1);
    div_flush = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    div_flush = 1'b0; res_ready = 1'b0;
    check("flush_done valid", 32'(res_valid), 32'd0);
    check("flush_done ready", 32'(div_ready), 32'd1);

    // Asynchronous reset in the middle of an operation.
    div_valid = 1'b1; div_op = 4'b0001; div_src1 = 32'd77; div_src2 = 32'd5;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset ready", 32'(div_ready), 32'd1);
    check("midreset valid", 32'(res_valid), 32'd0);
    check("midreset result", div_result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 40; i++) begin
      rop = 4'b0001 << $urandom_range(0, 3);
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = 32'hFFFF_FFFF;
        4:       rb = ra + 32'd1;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d", i), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
